if_fetch_unit: RTL and testbench

- Instruction-fetch stage; it is the producer side of the IF/ID pipeline register.
- Owns the PC and issues requests to a variable-latency instruction memory.
- Presents {pc_next, instruction} to IF/ID, which loads them whenever its own stall is low.
- Honours hazard-unit stall and branch/jump redirects, and inserts NOP (32'h0) bubbles while no instruction is ready.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/if_fetch_unit.sv | 119 +++++++++++
 tb/tb_if_fetch_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    // PC / address / instruction width
    localparam int PC_W = 32;

    // Bubble presented to IF/ID while no instruction is ready
    localparam logic [PC_W-1:0] NOP_INSTR = 32'h0000_0000;

    // Fetch FSM: issue request, wait for data, present instruction
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HAVE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency
// instruction memory and presents {pc_next, instruction} to IF/ID.
// Optional build macro FETCH_ALIGN_CHECK_EN enables a one-cycle
// misalign_err pulse after a redirect whose target has nonzero low bits.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [PC_W-1:0] PC_INCR  = 32'd4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [PC_W-1:0] imem_rdata,
    output logic [PC_W-1:0] pc_next_out,
    output logic [PC_W-1:0] instruction_out,
    output logic            inst_valid,
    output logic            misalign_err
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] inst_buf;
    logic            drop;       // one in-flight response must be discarded
    logic [PC_W-1:0] redir_aligned;
    logic            have;

    assign redir_aligned = {redirect_pc[PC_W-1:2], 2'b00};
    assign have          = (state == S_HAVE);

    // Outputs decode from registered state only; imem_rdata never reaches them directly
    assign imem_req        = (state == S_REQ) && !reset;
    assign imem_addr       = pc;
    assign inst_valid      = have;
    assign instruction_out = have ? inst_buf : NOP_INSTR;
    assign pc_next_out     = have ? (pc + PC_INCR) : '0;

    // Fetch FSM, PC register and instruction buffer; redirect outranks stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            inst_buf <= '0;
        end else if (redirect_valid) begin
            pc <= redir_aligned;
            case (state)
                S_REQ: begin
                    // If the old address was accepted this cycle, its data must be dropped
                    if (imem_ready) begin
                        drop  <= 1'b1;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        drop  <= 1'b0;
                        state <= S_REQ;
                    end else begin
                        drop <= 1'b1;
                    end
                end
                S_HAVE: begin
                    inst_buf <= '0;
                    state    <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            inst_buf <= imem_rdata;
                            state    <= S_HAVE;
                        end
                    end
                end
                S_HAVE: begin
                    if (!stall) begin
                        pc    <= pc + PC_INCR;
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    // Flag a redirect target with nonzero low bits for exactly one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) misalign_q <= 1'b0;
        else       misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end

    assign misalign_err = misalign_q;
`else
    // Low target bits are dropped silently in this build
    logic unused_redir_low;
    assign unused_redir_low = ^redirect_pc[1:0];
    assign misalign_err     = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc_next_out;
    logic [31:0] instruction_out;
    logic        inst_valid;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;
    int hs = 0;

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .pc_next_out    (pc_next_out),
        .instruction_out(instruction_out),
        .inst_valid     (inst_valid),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    // Count request handshakes seen by memory
    always @(posedge clk) if (imem_req && imem_ready) hs = hs + 1;

    task tick;
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch: accept in REQ, return data the next cycle; ends in HAVE
    task fetch_one(input logic [31:0] data);
        imem_ready = 1'b1;
        tick;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    endtask

    task test_reset;
        reset = 1'b1;
        tick;
        tick;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b want=0", imem_req); end
        checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", inst_valid); end
        checks++; if (instruction_out !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h want=0", instruction_out); end
        checks++; if (pc_next_out !== 32'h0) begin errors++; $display("FAIL reset_pcnext got=%h want=0", pc_next_out); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%0b want=0", misalign_err); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h want=0", imem_addr); end
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL release_req got=%0b want=1", imem_req); end
    endtask

    task test_basic_fetch;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL basic_addr0 got=%h want=0", imem_addr); end
        imem_ready = 1'b1;
        tick;
        imem_ready = 1'b0;
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL basic_wait got=%0b/%0b want=0/0", imem_req, inst_valid); end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2001_0005;
        tick;
        imem_rvalid = 1'b0;
        checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%0b want=1", inst_valid); end
        checks++; if (instruction_out !== 32'h2001_0005) begin errors++; $display("FAIL basic_instr got=%h want=20010005", instruction_out); end
        checks++; if (pc_next_out !== 32'h4) begin errors++; $display("FAIL basic_pcnext got=%h want=4", pc_next_out); end
        tick;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL basic_next_addr got=%0b/%h want=1/4", imem_req, imem_addr); end
        checks++; if (inst_valid !== 1'b0 || instruction_out !== 32'h0) begin errors++; $display("FAIL basic_bubble got=%0b/%h want=0/0", inst_valid, instruction_out); end
    endtask

    task test_stall;
        fetch_one(32'h1111_2222);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (inst_valid !== 1'b1 || instruction_out !== 32'h1111_2222 || pc_next_out !== 32'h8 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d] got=%0b/%h/%h/%0b want=1/11112222/8/0", i, inst_valid, instruction_out, pc_next_out, imem_req);
            end
            tick;
        end
        stall = 1'b0;
        tick;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL stall_release got=%0b/%h want=1/8", imem_req, imem_addr); end
    endtask

    task test_latency;
        int hs0;
        hs0 = hs;
        imem_ready = 1'b1;
        tick;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (inst_valid !== 1'b0 || instruction_out !== 32'h0 || imem_req !== 1'b0) begin
                errors++;
                $display("FAIL lat_wait[%0d] got=%0b/%h/%0b want=0/0/0", i, inst_valid, instruction_out, imem_req);
            end
            tick;
        end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h3333_4444;
        tick;
        imem_rvalid = 1'b0;
        checks++; if (inst_valid !== 1'b1 || instruction_out !== 32'h3333_4444 || pc_next_out !== 32'hC) begin errors++; $display("FAIL lat_data got=%0b/%h/%h want=1/33334444/c", inst_valid, instruction_out, pc_next_out); end
        checks++; if (hs - hs0 !== 1) begin errors++; $display("FAIL lat_handshakes got=%0d want=1", hs - hs0); end
        tick;
    endtask

    task test_redirect_wait;
        imem_ready = 1'b1;
        tick;
        imem_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick;
        redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL rdw_wait got=%0b/%0b want=0/0", imem_req, inst_valid); end
        tick;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick;
        imem_rvalid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || instruction_out !== 32'h0) begin errors++; $display("FAIL rdw_dropped got=%0b/%h want=0/0", inst_valid, instruction_out); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rdw_newaddr got=%0b/%h want=1/100", imem_req, imem_addr); end
        fetch_one(32'h5555_0000);
        checks++; if (inst_valid !== 1'b1 || instruction_out !== 32'h5555_0000 || pc_next_out !== 32'h104) begin errors++; $display("FAIL rdw_after got=%0b/%h/%h want=1/55550000/104", inst_valid, instruction_out, pc_next_out); end
        tick;
    endtask

    task test_redirect_stall;
        fetch_one(32'h6666_0000);
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        tick;
        redirect_valid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || instruction_out !== 32'h0 || pc_next_out !== 32'h0) begin errors++; $display("FAIL rds_bubble got=%0b/%h/%h want=0/0/0", inst_valid, instruction_out, pc_next_out); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin errors++; $display("FAIL rds_addr got=%0b/%h want=1/2000", imem_req, imem_addr); end
        stall = 1'b0;
    endtask

    task test_misalign;
        logic exp_pulse;
`ifdef FETCH_ALIGN_CHECK_EN
        exp_pulse = 1'b1;
`else
        exp_pulse = 1'b0;
`endif
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        #1;
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_before got=%0b want=0", misalign_err); end
        tick;
        redirect_valid = 1'b0;
        checks++; if (misalign_err !== exp_pulse) begin errors++; $display("FAIL mis_pulse got=%0b want=%0b", misalign_err, exp_pulse); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL mis_addr got=%h want=100", imem_addr); end
        tick;
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL mis_after got=%0b want=0", misalign_err); end
    endtask

    task test_wrap;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick;
        redirect_valid = 1'b0;
        fetch_one(32'h7777_0000);
        checks++; if (inst_valid !== 1'b1 || pc_next_out !== 32'h0) begin errors++; $display("FAIL wrap_pcnext got=%0b/%h want=1/0", inst_valid, pc_next_out); end
        tick;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got=%h want=0", imem_addr); end
    endtask

    task test_reset_mid;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        tick;
        redirect_valid = 1'b0;
        imem_ready = 1'b1;
        tick;
        imem_ready = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_async got=%0b/%h want=0/0", imem_req, imem_addr); end
        tick;
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0BAD_0BAD;
        tick;
        imem_rvalid = 1'b0;
        checks++; if (inst_valid !== 1'b0 || instruction_out !== 32'h0) begin errors++; $display("FAIL rmid_ignored got=%0b/%h want=0/0", inst_valid, instruction_out); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_req got=%0b/%h want=1/0", imem_req, imem_addr); end
    endtask

    initial begin
        test_reset;
        test_basic_fetch;
        test_stall;
        test_latency;
        test_redirect_wait;
        test_redirect_stall;
        test_misalign;
        test_wrap;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
